// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state type, widths and byte-to-word address map for the SRAM controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int SRAM_ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Byte offsets below base wrap; the low two byte-lane bits are dropped.
  function automatic logic [SRAM_ADDR_W-1:0] to_word(input logic [31:0] addr,
                                                     input logic [31:0] base);
    return SRAM_ADDR_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// rtl/sram_read_buffer.sv - one-entry even/odd word pair buffer, built only with SRAM_READ_BUFFER_EN
module sram_read_buffer
  import sram_ctrl_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   lookup_en,
  input  logic [SRAM_ADDR_W-1:0] lookup_word,
  output logic                   hit,
  output logic [DATA_W-1:0]      hit_data,
  input  logic                   fill_en,
  input  logic [SRAM_ADDR_W-2:0] fill_tag,
  input  logic [DATA_W-1:0]      fill_even,
  input  logic [DATA_W-1:0]      fill_odd,
  input  logic                   upd_en,
  input  logic [SRAM_ADDR_W-1:0] upd_word,
  input  logic [DATA_W-1:0]      upd_data
);

  logic                   valid;
  logic [SRAM_ADDR_W-2:0] tag;
  logic [DATA_W-1:0]      even_word;
  logic [DATA_W-1:0]      odd_word;

  assign hit      = lookup_en && valid && (tag == lookup_word[SRAM_ADDR_W-1:1]);
  assign hit_data = lookup_word[0] ? odd_word : even_word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid     <= 1'b0;
      tag       <= '0;
      even_word <= '0;
      odd_word  <= '0;
    end else if (fill_en) begin
      valid     <= 1'b1;
      tag       <= fill_tag;
      even_word <= fill_even;
      odd_word  <= fill_odd;
    end else if (upd_en && valid && (tag == upd_word[SRAM_ADDR_W-1:1])) begin
      if (upd_word[0]) odd_word <= upd_data;
      else             even_word <= upd_data;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage to SRAM sequencer; optional read buffer under SRAM_READ_BUFFER_EN
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  inout  wire  [DATA_W-1:0]      SRAM_DQ0,
  inout  wire  [DATA_W-1:0]      SRAM_DQ1
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   op_write;
  logic                   dq0_oe;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      read_data_q;
  logic [SRAM_ADDR_W-1:0] req_word;
  logic                   req;
  logic                   last_cnt;
  logic                   buf_hit;
  logic [DATA_W-1:0]      buf_data;
  logic [DATA_W-1:0]      sram_word;

  assign req       = rd_en | wr_en;
  assign req_word  = to_word(address, BASE_ADDR);
  assign last_cnt  = (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign sram_word = SRAM_ADDR[0] ? SRAM_DQ1 : SRAM_DQ0;

  assign SRAM_DQ0 = dq0_oe ? wdata_q : 'z;
  assign SRAM_DQ1 = 'z;

`ifdef SRAM_READ_BUFFER_EN
  sram_read_buffer u_read_buffer (
    .CLK         (CLK),
    .RST         (RST),
    .lookup_en   ((state == IDLE) && rd_en && !wr_en),
    .lookup_word (req_word),
    .hit         (buf_hit),
    .hit_data    (buf_data),
    .fill_en     ((state == ACCESS) && last_cnt && !op_write),
    .fill_tag    (SRAM_ADDR[SRAM_ADDR_W-1:1]),
    .fill_even   (SRAM_DQ0),
    .fill_odd    (SRAM_DQ1),
    .upd_en      ((state == DONE) && op_write),
    .upd_word    (SRAM_ADDR),
    .upd_data    (wdata_q)
  );
  assign read_data = buf_hit ? buf_data : read_data_q;
`else
  assign buf_hit   = 1'b0;
  assign buf_data  = '0;
  assign read_data = read_data_q;
`endif

  always_comb begin
    ready = 1'b0;
    if (!RST) begin
      case (state)
        IDLE:    ready = !req || buf_hit;
        DONE:    ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      dq0_oe      <= 1'b0;
      wdata_q     <= '0;
      read_data_q <= '0;
      SRAM_ADDR   <= '0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (buf_hit) begin
            // A buffer hit still counts as a completed read, so the held value follows it.
            read_data_q <= buf_data;
          end else if (req) begin
            SRAM_ADDR <= req_word;
            wdata_q   <= write_data;
            op_write  <= wr_en;
            SRAM_WE_N <= !wr_en;
            dq0_oe    <= wr_en;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (last_cnt) begin
            if (!op_write) read_data_q <= sram_word;
            SRAM_WE_N <= 1'b1;
            dq0_oe    <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with a behavioural SRAM model
module tb_sram_controller;

  localparam int WAIT = 5;
  localparam int LAT  = WAIT + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [16:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  wire  [31:0] SRAM_DQ0;
  wire  [31:0] SRAM_DQ1;

  sram_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDR(32'd1024)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_DQ0   (SRAM_DQ0),
    .SRAM_DQ1   (SRAM_DQ1)
  );

  always #10 CLK = ~CLK;

  logic [31:0] mem [0:(1<<17)-1];
  bit          init_mem = 1'b1;

  always @(posedge CLK) begin
    if (init_mem) begin
      mem[4]  <= 32'h11111111;
      mem[5]  <= 32'h22222222;
      mem[17] <= 32'h17171717;
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR] <= SRAM_DQ0;
    end
  end

  assign SRAM_DQ0 = SRAM_WE_N ? mem[{SRAM_ADDR[16:1], 1'b0}] : 32'bz;
  assign SRAM_DQ1 = mem[{SRAM_ADDR[16:1], 1'b1}];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ready_cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic        mb_valid = 1'b0;
  logic [15:0] mb_tag = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; leaves inputs cleared at posedge+1 right after the ready cycle.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d, input string nm);
    exp_t e;
    exp_t got;
    int   lat;
    bit   hit;
    hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    begin
      logic [16:0] word;
      word = 17'((a - 32'd1024) >> 2);
      if (r && !w && mb_valid && mb_tag == word[16:1]) hit = 1'b1;
      if (r && !w && !hit) begin
        mb_valid = 1'b1;
        mb_tag   = word[16:1];
      end
    end
`endif
    e.data = exp_d;
    e.lat  = hit ? 0 : LAT;
    sb.push_back(e);
    rd_en = r; wr_en = w; address = a; write_data = d;
    lat = 0;
    @(negedge CLK);
    while (!ready && lat < 40) begin
      lat++;
      @(negedge CLK);
    end
    got = sb.pop_front();
    check({nm, "_ready"}, ready, 1);
    check({nm, "_lat"}, lat, got.lat);
    check({nm, "_data"}, read_data, got.data);
    ready_cyc = cyc;
    @(posedge CLK); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int r1;
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[1]  = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h11111111};
    vecs[2]  = '{1'b1, 1'b0, 32'd1044, 32'h0,        32'h22222222};
    vecs[3]  = '{1'b0, 1'b1, 32'd1044, 32'h7,        32'h22222222};
    vecs[4]  = '{1'b1, 1'b0, 32'd1044, 32'h0,        32'h00000007};
    vecs[5]  = '{1'b1, 1'b1, 32'd1028, 32'h5,        32'h00000007};
    vecs[6]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h00000005};
    vecs[7]  = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 32'd1100, 32'hA5A50F0F, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'd1100, 32'h0,        32'hA5A50F0F};
    vecs[10] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h11111111};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", ready, 0);
    check("rst_we_n", SRAM_WE_N, 1);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_rdata", read_data, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    init_mem = 1'b0;
    @(negedge CLK);
    check("idle_ready", ready, 1);
    @(posedge CLK); #1;

    // Store trace to word 2, one check per cycle of the access.
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge CLK);
      check($sformatf("st_ready_c%0d", c), ready, (c == LAT) ? 1 : 0);
      check($sformatf("st_we_n_c%0d", c), SRAM_WE_N, (c >= 1 && c <= WAIT) ? 0 : 1);
      if (c >= 1 && c <= WAIT) check($sformatf("st_addr_c%0d", c), SRAM_ADDR, 2);
    end
    check("st_rdata", read_data, 0);
    @(posedge CLK); #1;
    wr_en = 1'b0;
    check("mem2", mem[2], 32'hCAFEF00D);

    // vecs[0] expects the reset value 0 in read_data; fix it up here so the table reads naturally.
    vecs[0].exp_rdata = 32'h0;
    for (int i = 0; i < 11; i++)
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             $sformatf("v%0d", i));

    // Reset in cycle 3 of a store to word 3.
    wr_en = 1'b1; address = 32'd1036; write_data = 32'hBAD0BAD0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_ready_c3", ready, 0);
    @(posedge CLK); #1;
    wr_en = 1'b0;
    @(negedge CLK);
    check("mid_rst_ready_c4", ready, 0);
    check("mid_rst_we_n", SRAM_WE_N, 1);
    check("mid_rst_addr", SRAM_ADDR, 0);
    check("mid_rst_rdata", read_data, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    mb_valid = 1'b0;
    @(negedge CLK);
    check("post_rst_idle_ready", ready, 1);
    @(posedge CLK); #1;
    do_req(1'b1, 1'b0, 32'd1040, 32'h0, 32'h11111111, "post_rst_rd");

    // Back-to-back load then store, no idle gap inserted by the requester.
    do_req(1'b1, 1'b0, 32'd1092, 32'h0, 32'h17171717, "b2b_rd");
    r1 = ready_cyc;
    do_req(1'b0, 1'b1, 32'd1096, 32'h0BB00BB0, 32'h17171717, "b2b_wr");
    check("b2b_gap", ready_cyc - r1, WAIT + 2);

    check("mem0", mem[0], 32'hDEADBEEF);
    check("mem1", mem[1], 32'h5);
    check("mem5", mem[5], 32'h7);
    check("mem19", mem[19], 32'hA5A50F0F);
    check("mem18", mem[18], 32'h0BB00BB0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencing controller between the MIPS pipeline MEM stage and the external 32-bit SRAM (17-bit word address, even/odd word ports DQ0/DQ1, active-low write enable).
- Accepts one load or store at a time, translates the byte address to an SRAM word address, and drives the SRAM for a fixed number of wait cycles.
- Holds `ready` low while the access is in flight, which freezes the pipeline.
- Returns the loaded word with a one-cycle `ready` pulse.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: SRAM cycles per access. Covers the 60 ns DQ1 settle at a 20 ns clock with margin. Must be ≥ 1.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request from MEM stage.
- `wr_en` in 1: store request from MEM stage.
- `address` in 32: byte address.
- `write_data` in 32: store data.
- `read_data` out 32: load result.
- `ready` out 1: access complete; pipeline may advance.
- `SRAM_ADDR` out 17: SRAM word address.
- `SRAM_WE_N` out 1: SRAM write enable, active low.
- `SRAM_DQ0` inout 32: even-word port. Driven only during writes.
- `SRAM_DQ1` inout 32: odd-word port. Never driven; always `z`.

## Operation
- Address map: `word = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - `address[1:0]` is ignored.
  - `word[0]` selects DQ1 when 1, DQ0 when 0.
- Request hold rule: the requester keeps `rd_en`/`wr_en`/`address`/`write_data` stable until `ready` is sampled high.
- Simultaneous `rd_en` and `wr_en`: the write wins; `read_data` is unchanged.
- State `IDLE`:
  - `ready = !(rd_en | wr_en)`.
  - `SRAM_WE_N = 1`.
  - On a request: latch `word`, `write_data` and op; clear the counter; go to `ACCESS`.
- State `ACCESS`:
  - `SRAM_ADDR` = latched word.
  - Write op: `SRAM_WE_N = 0`, `SRAM_DQ0` = latched data. Repeated identical writes are harmless.
  - Read op: `SRAM_WE_N = 1`, DQ0 at `z`.
  - The counter increments each cycle. At count `WAIT_CYCLES-1`:
    - a read captures DQ0/DQ1 (selected by `word[0]`) into `read_data`;
    - the FSM goes to `DONE`.
  - `ready = 0`.
- State `DONE`:
  - `ready = 1` for exactly one cycle.
  - `SRAM_WE_N = 1`, DQ0 at `z`.
  - Next state is `IDLE`.
- Reset (`RST` high at an edge), including mid-access:
  - state `IDLE`, counter 0;
  - `SRAM_WE_N = 1`, `SRAM_ADDR = 0`, `read_data = 0`, DQ0 at `z`.
  - `ready` is forced to 0 while `RST` is high.
  - A write aborted mid-access leaves the SRAM word undefined.

## Timing
- Request first sampled in `IDLE` at edge 0:
  - `ACCESS` spans cycles 1..`WAIT_CYCLES`;
  - `DONE` (`ready = 1`) is cycle `WAIT_CYCLES+1`. Default: cycle 6.
- `read_data` is registered. It is valid from the `DONE` cycle and holds until the next completed read or reset.
- Back-to-back requests: the next request is accepted in the `IDLE` cycle after `DONE`, giving a minimum period of `WAIT_CYCLES+2` cycles.
- `ready` is combinational from state and request inputs, with no combinational path from SRAM_DQ.

## Configuration
- Macro `SRAM_READ_BUFFER_EN`. When defined, a one-entry, 64-bit read buffer is compiled in:
  - Contents: `{tag = word[16:1], valid, even, odd}`.
  - Fill: every completed read loads both DQ0 and DQ1 and sets `valid`.
  - Hit (IDLE read with `valid` and matching tag): `ready = 1` in the same cycle, with no SRAM access. `read_data` is combinationally muxed from the buffer word selected by `word[0]`.
  - A write whose tag matches updates the corresponding buffer word when it reaches `DONE`.
  - Reset clears `valid`.
- When undefined: no buffer. Every read takes `WAIT_CYCLES+2` cycles and `read_data` is purely registered.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum `{IDLE, ACCESS, DONE}`;
  - `SRAM_ADDR_W = 17`, `DATA_W = 32`;
  - default `BASE_ADDR`;
  - address-translation function.
- Sub-module `sram_read_buffer` (tag/valid/data storage and hit compare), instantiated only under `SRAM_READ_BUFFER_EN`.

## Test plan
- Store: `wr_en = 1`, `address = 1024`, `write_data = 0xDEADBEEF`.
  - `ready` = 0 in cycles 0–5 and 1 in cycle 6.
  - `SRAM_WE_N` = 0 in cycles 1–5.
  - SRAM word 0 = `0xDEADBEEF`.
- Load: SRAM words 4/5 preloaded with `0x11111111`/`0x22222222`.
  - Read `address = 1044` (word 5): `read_data = 0x22222222` in cycle 6.
  - Read `address = 1040` (word 4): `read_data = 0x11111111`.
- Simultaneous `rd_en = wr_en = 1`, `address = 1028`, `write_data = 0x5`: word 1 = 5 and `read_data` is unchanged.
- Reset mid-access: assert `RST` in cycle 3 of a store.
  - Next cycle: `SRAM_WE_N = 1`, DQ0 at `z`, state `IDLE`, `ready = 0` while `RST` is high.
  - The following request completes normally.
- Back-to-back: load then store, both requests held. Second `ready` arrives exactly 7 cycles after the first.
- With `SRAM_READ_BUFFER_EN`:
  - Read 1040, then read 1044: second read has `ready = 1` in cycle 0 and returns `0x22222222`.
  - Store `0x7` to 1044, then read 1044: returns 7 from the buffer.
